// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light encodings and phase codes for the intersection scheduler
package traffic_pkg;

    // Lamp buses are {R,Y,G} one-hot.
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [2:0] {
        PH_HG   = 3'd0,
        PH_HY   = 3'd1,
        PH_FG   = 3'd2,
        PH_FY   = 3'd3,
        PH_WALK = 3'd4,
        PH_EMG  = 3'd5
    } phase_t;

endpackage

// File: rtl/phase_tick_timer.sv
// rtl/phase_tick_timer.sv - tick prescaler plus saturating per-phase tick counter
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart prescaler and counter (asserted on every phase change)
//   tick       : high for one cycle every TICK_DIV cycles
//   count      : ticks elapsed in the current phase, saturating at all ones
module phase_tick_timer #(
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            presc <= '0;
            count <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && (count != {CNT_W{1'b1}})) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - highway/farm intersection phase FSM with ped and emergency requests
//
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   C                : farm-road vehicle sensor (already synchronous to clk)
//   ped_req          : pedestrian button, pulse or level, latched until WALK is served
//   emg_req          : emergency pre-emption level
//   light_highway    : highway lamps {R,Y,G}
//   light_farm       : farm lamps {R,Y,G}
//   walk             : pedestrian walk lamp
//   phase            : current phase code
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 8,
    parameter int HW_MIN   = 20,
    parameter int FARM_MAX = 10,
    parameter int YEL_T    = 3,
    parameter int WALK_T   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       C,
    input  logic       ped_req,
    input  logic       emg_req,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] HW_LAST   = CNT_W'(HW_MIN - 1);
    localparam logic [CNT_W-1:0] FARM_LAST = CNT_W'(FARM_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

    phase_t           state;
    phase_t           next_state;
    logic             ped_pending;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             state_change;

    assign state_change = (next_state != state);

    phase_tick_timer #(
        .TICK_DIV(TICK_DIV),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_change),
        .tick (tick),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PH_HG;
        end else begin
            state <= next_state;
        end
    end

    // The request is consumed on the edge that leaves WALK; presses during
    // WALK are already being served and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
        end else if (state == PH_WALK) begin
            if (next_state != PH_WALK) begin
                ped_pending <= 1'b0;
            end
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end

    // Emergency acts immediately only where it cannot shorten a yellow.
    always_comb begin
        next_state = state;
        case (state)
            PH_HG: begin
                if (emg_req) begin
                    next_state = PH_HY;
                end else if (tick && (count >= HW_LAST) && (C || ped_pending)) begin
                    next_state = PH_HY;
                end
            end
            PH_HY: begin
                if (tick && (count == YEL_LAST)) begin
                    if (emg_req)          next_state = PH_EMG;
                    else if (ped_pending) next_state = PH_WALK;
                    else                  next_state = PH_FG;
                end
            end
            PH_FG: begin
                if (emg_req) begin
                    next_state = PH_FY;
                end else if (tick && (!C || (count == FARM_LAST))) begin
                    next_state = PH_FY;
                end
            end
            PH_FY: begin
                if (tick && (count == YEL_LAST)) begin
                    next_state = emg_req ? PH_EMG : PH_HG;
                end
            end
            PH_WALK: begin
                if (emg_req) begin
                    next_state = PH_EMG;
                end else if (tick && (count == WALK_LAST)) begin
                    next_state = PH_HG;
                end
            end
            PH_EMG: begin
                if (!emg_req) begin
                    next_state = PH_HG;
                end
            end
            default: next_state = PH_HG;
        endcase
    end

    // Unknown encodings show all-red so no conflicting greens can appear.
    always_comb begin
        light_highway = LIGHT_RED;
        light_farm    = LIGHT_RED;
        walk          = 1'b0;
        case (state)
            PH_HG:   light_highway = LIGHT_GRN;
            PH_HY:   light_highway = LIGHT_YEL;
            PH_FG:   light_farm    = LIGHT_GRN;
            PH_FY:   light_farm    = LIGHT_YEL;
            PH_WALK: walk          = 1'b1;
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - self-checking bench for intersection_phase_scheduler
module tb_intersection_phase_scheduler;

    localparam int TD = 10, HW_MIN = 20, FARM_MAX = 10, YEL_T = 3, WALK_T = 5, CMAX = 255;
    localparam int P_HG = 0, P_HY = 1, P_FG = 2, P_FY = 3, P_WALK = 4, P_EMG = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, C = 1'b0, ped_req = 1'b0, emg_req = 1'b0;
    logic [2:0] light_highway, light_farm, phase;
    logic       walk;

    always #5 clk = ~clk;

    intersection_phase_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .C            (C),
        .ped_req      (ped_req),
        .emg_req      (emg_req),
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .walk         (walk),
        .phase        (phase)
    );

    int total = 0, bad = 0, cyc = 0;
    int m_phase = 0, m_elapsed = 0;
    bit m_ped = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // {highway, farm, walk, phase} expected for a phase
    function automatic logic [9:0] expect_out(input int ph);
        case (ph)
            P_HG:    return {3'b001, 3'b100, 1'b0, 3'd0};
            P_HY:    return {3'b010, 3'b100, 1'b0, 3'd1};
            P_FG:    return {3'b100, 3'b001, 1'b0, 3'd2};
            P_FY:    return {3'b100, 3'b010, 1'b0, 3'd3};
            P_WALK:  return {3'b100, 3'b100, 1'b1, 3'd4};
            default: return {3'b100, 3'b100, 1'b0, 3'd5};
        endcase
    endfunction

    // Reference: time in phase is tracked as raw elapsed cycles; ticks fall
    // on every TD-th cycle and the tick count is elapsed/TD, capped.
    task automatic model_edge();
        bit tick;
        int ticks, nxt;
        if (!rst_n) begin
            m_phase = P_HG; m_elapsed = 0; m_ped = 0;
            return;
        end
        tick  = (m_elapsed % TD) == TD - 1;
        ticks = m_elapsed / TD;
        if (ticks > CMAX) ticks = CMAX;
        nxt = m_phase;
        case (m_phase)
            P_HG:   if (emg_req || (tick && ticks >= HW_MIN - 1 && (C || m_ped))) nxt = P_HY;
            P_HY:   if (tick && ticks == YEL_T - 1) nxt = emg_req ? P_EMG : (m_ped ? P_WALK : P_FG);
            P_FG:   if (emg_req || (tick && (!C || ticks == FARM_MAX - 1))) nxt = P_FY;
            P_FY:   if (tick && ticks == YEL_T - 1) nxt = emg_req ? P_EMG : P_HG;
            P_WALK: if (emg_req) nxt = P_EMG; else if (tick && ticks == WALK_T - 1) nxt = P_HG;
            default: if (!emg_req) nxt = P_HG;
        endcase
        if (m_phase == P_WALK) begin
            if (nxt != P_WALK) m_ped = 0;
        end else if (ped_req) begin
            m_ped = 1;
        end
        m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase = nxt;
    endtask

    task automatic step(input logic r, input logic c, input logic p, input logic e);
        rst_n = r; C = c; ped_req = p; emg_req = e;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("outputs", {22'd0, light_highway, light_farm, walk, phase}, {22'd0, expect_out(m_phase)});
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cyc = 0;
    endtask

    initial begin
        do_reset();
        check("rst_hw", light_highway, 3'b001);
        check("rst_farm", light_farm, 3'b100);
        check("rst_walk", walk, 1'b0);
        check("rst_phase", phase, 3'd0);

        // C held: HY 200, FG 230, FY 330 (farm cap), HG 360, HY again 560
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            case (cyc)
                199: check("c_hold_hg199", phase, 3'd0);
                200: check("c_hold_hy200", phase, 3'd1);
                230: check("c_hold_fg230", phase, 3'd2);
                330: check("c_hold_fy330", phase, 3'd3);
                360: check("c_hold_hg360", phase, 3'd0);
                560: check("c_hold_hy560", phase, 3'd1);
                default: ;
            endcase
        end

        // no requests: highway green indefinitely
        do_reset();
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_phase", phase, 3'd0);
        check("idle_hw", light_highway, 3'b001);

        // farm green cut short when C drops
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, (i < 250), 1'b0, 1'b0);
            case (cyc)
                259: check("c_drop_fg259", phase, 3'd2);
                260: check("c_drop_fy260", phase, 3'd3);
                290: check("c_drop_hg290", phase, 3'd0);
                default: ;
            endcase
        end

        // pedestrian pulse, second pulse during WALK ignored
        do_reset();
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 1'b0, (i == 50 || i == 250), 1'b0);
            case (cyc)
                200: check("ped_hy200", phase, 3'd1);
                230: check("ped_walk230", {light_highway, light_farm, walk}, 7'b100_100_1);
                280: check("ped_hg280", phase, 3'd0);
                481: check("ped_cleared481", phase, 3'd0);
                default: ;
            endcase
        end

        // emergency in HG, held, released
        do_reset();
        for (int i = 0; i < 650; i++) begin
            step(1'b1, 1'b0, 1'b0, (i >= 100 && i < 400));
            case (cyc)
                101: check("emg_hy101", phase, 3'd1);
                130: check("emg_hy130", phase, 3'd1);
                131: check("emg_emg131", phase, 3'd5);
                400: check("emg_hold400", phase, 3'd5);
                401: check("emg_hg401", phase, 3'd0);
                default: ;
            endcase
        end

        // reset during FG with a pending ped request
        do_reset();
        for (int i = 0; i < 250; i++) step(1'b1, 1'b1, (i == 240), 1'b0);
        check("pre_rst_fg", phase, 3'd2);
        do_reset();
        check("mid_rst_out", {light_highway, light_farm, walk, phase}, 10'b001_100_0_000);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("mid_rst_ped_clr", phase, 3'd0);

        // randomized run against the model
        do_reset();
        begin
            logic rc = 0, re = 0;
            for (int i = 0; i < 20000; i++) begin
                if ($urandom_range(0, 59) == 0) rc = ~rc;
                if ($urandom_range(0, 399) == 0) re = ~re;
                step(($urandom_range(0, 2999) != 0), rc, ($urandom_range(0, 199) == 0), re);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Sequences a highway/farm-road intersection through timed light phases. Arbitrates three request sources: the farm-road vehicle sensor C, a latched pedestrian request, and an emergency pre-emption level. Drives the 3-bit highway and farm light buses and a walk signal. Sits above the light-output logic as the single owner of phase timing.

Parameters:
TICK_DIV, 10, clock cycles per timing tick (>=2)
CNT_W, 8, width of the phase tick counter
HW_MIN, 20, minimum highway green, in ticks (>=1)
FARM_MAX, 10, maximum farm green, in ticks (>=1)
YEL_T, 3, yellow duration, in ticks (>=1)
WALK_T, 5, all-red pedestrian walk duration, in ticks (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
C  in  1  farm-road vehicle sensor, level
ped_req  in  1  pedestrian button, single-cycle pulse or level
emg_req  in  1  emergency pre-emption, level
light_highway  out  3  {R,Y,G} one-hot: 100 red, 010 yellow, 001 green
light_farm  out  3  same encoding
walk  out  1  pedestrian walk lamp
phase  out  3  current phase code (debug/status)

Behaviour:
- Reset is sampled on a clk rising edge with rst_n=0. It sets state HG, tick prescaler 0, tick counter 0 and ped_pending 0.
- Outputs after reset: light_highway=001, light_farm=100, walk=0, phase=0. Reset asserted mid-phase aborts that phase immediately on the next edge.
- Outputs are a Moore decode of the state register, so they change in the same cycle the state register updates.
- Phase codes, with (highway, farm, walk):
  - HG=0: 001, 100, 0
  - HY=1: 010, 100, 0
  - FG=2: 100, 001, 0
  - FY=3: 100, 010, 0
  - WALK=4: 100, 100, 1
  - EMG=5: 100, 100, 0
- Prescaler counts 0..TICK_DIV-1. tick=1 when prescaler==TICK_DIV-1.
- Tick counter increments on tick and saturates at 2^CNT_W-1.
- Both the prescaler and the tick counter clear on every state change. A phase of D ticks therefore lasts exactly D*TICK_DIV cycles.
- "expire(D)" means tick && counter==D-1. All exit conditions are evaluated only on tick cycles, except emergency pre-emption.
- ped_pending:
  - Set when ped_req=1 in any state other than WALK.
  - Cleared on the edge leaving WALK.
  - ped_req during WALK is ignored.
- Transitions (priority in listed order):
  - HG: emg_req -> HY (on any cycle, not waiting for a tick). Otherwise, when counter>=HW_MIN-1 on a tick and (C || ped_pending) -> HY. Otherwise stay, with no maximum.
  - HY: expire(YEL_T) -> EMG if emg_req, else WALK if ped_pending, else FG.
  - FG: emg_req -> FY (any cycle). Otherwise, on a tick when !C or counter==FARM_MAX-1 -> FY.
  - FY: expire(YEL_T) -> EMG if emg_req, else HG.
  - WALK: emg_req -> EMG (any cycle, since lights are already all red). Otherwise expire(WALK_T) -> HG.
  - EMG: stay while emg_req=1. On emg_req=0 -> HG, with the counter cleared.
- Yellow is never skipped or shortened. emg_req arriving during HY/FY waits for the yellow to expire.
- The timed-path C is sampled directly. It must be synchronous to clk; synchronisation happens upstream.
- No illegal light combination is ever output. Unused state encodings decode to EMG outputs and transition to HG on the next edge.

Decomposition:
- Package traffic_pkg holds:
  - light encodings LIGHT_RED/LIGHT_YEL/LIGHT_GRN (3-bit)
  - phase enum PH_HG..PH_EMG (3-bit)
- Sub-module phase_tick_timer holds the prescaler, saturating tick counter, clear input, and tick/count outputs. Parameters: TICK_DIV and CNT_W.
- The FSM, ped latch and output decode live in the top module.

Test Plan:
(defaults; cycle counts measured from the first edge with rst_n=1)
- C=1 held, no other requests -> HY entered at cycle 200, FG at 230, FY at 330 (FARM_MAX cap), HG at 360; the cycle then repeats.
- C=0 always -> remains HG (001/100) for 2000 cycles; phase=0 throughout.
- C=1 from cycle 0, C=0 at cycle 250 -> FG exits at the first tick with !C: FY entered at cycle 260, HG at 290.
- ped_req 1-cycle pulse at cycle 50, C=0 -> HY at 200, WALK at 230 (walk=1, both lights 100), HG at 280; ped_pending=0 afterwards. A second pulse during WALK has no effect.
- emg_req=1 at cycle 100 (in HG) -> HY at 101, EMG at 131. Holding emg_req keeps EMG; releasing it at cycle 400 -> HG at 401 with the counter at 0.
- rst_n=0 for one edge while in FG -> next cycle outputs are 001/100, walk=0, phase=0; ped_pending cleared.
